fetch_controller: RTL and testbench
===================================

// Module: fetch_controller
// PURPOSE
//   Sequences the Fetch stage: owns the PC and issues one instruction-memory
//   read at a time (req/gnt, then rvalid). It holds each fetched word in a
//   one-entry buffer and hands it to Decode over a valid/ready handshake.
//   Redirects from Execute (branch/jump/trap) discard stale in-flight data.
//   Sits between the core's control path and the FetchStep/instruction memory port.
// PARAMETERS
//   RESET_PC   32'h0000_0000   PC loaded on reset
//   PC_STEP    4               PC increment per fetched instruction (bytes)
// PORTS
//   clk_i            in   1   clock; all logic on rising edge
//   rst_i            in   1   reset, synchronous, active-low
//   enable_step_i    in   1   fetch enable; low = stop issuing new requests
//   redirect_i       in   1   redirect strobe (one cycle)
//   redirect_pc_i    in   32  redirect target; bits[1:0] ignored (forced 00)
//   mem_req_o        out  1   memory read request
//   mem_adres_o      out  32  request address (= PC)
//   mem_gnt_i        in   1   request accepted this cycle
//   mem_rvalid_i     in   1   read data valid
//   mem_rdata_i      in   32  read data
//   inst_valid_o     out  1   instruction buffer holds a valid word
//   instruction_o    out  32  buffered instruction
//   inst_pc_o        out  32  PC of buffered instruction
//   inst_ready_i     in   1   Decode accepts buffered word
//   busy_o           out  1   state != IDLE
// BEHAVIOUR
//   Reset (rst_i==0 at edge, wins over all inputs, any state): state=IDLE,
//     pc=RESET_PC, drop=0; all outputs 0 except mem_adres_o=RESET_PC.
//   States: IDLE, REQ, WAIT, HOLD. Max one outstanding request. drop flag marks
//     an in-flight response as stale.
//   IDLE: no request. enable_step_i=1 -> REQ next cycle. redirect_i -> pc=target, stay IDLE.
//   REQ: mem_req_o=1, mem_adres_o=pc. Once asserted, req is not retracted
//     (even if enable_step_i drops) until granted.
//     gnt=1 -> WAIT. redirect without gnt -> pc=target, stay REQ (new address next cycle).
//     redirect with gnt -> pc=target, drop=1, go WAIT.
//   WAIT: mem_req_o=0. rvalid=1 and drop=0 and no redirect -> instruction_o=rdata,
//     inst_pc_o=pc, pc=pc+PC_STEP, go HOLD.
//     rvalid=1 and drop=1 -> discard, drop=0, go REQ if enable else IDLE.
//     redirect while waiting -> pc=target, drop=1. redirect same cycle as rvalid ->
//     discard, drop=0, pc=target, go REQ if enable else IDLE.
//   HOLD: inst_valid_o=1; instruction_o/inst_pc_o stable until accepted.
//     inst_ready_i=1 -> inst_valid_o=0 next cycle, go REQ if enable else IDLE.
//     redirect (with or without ready) -> buffer invalidated next cycle, pc=target,
//     go REQ if enable else IDLE.
//   Latency: req to Decode-valid = gnt latency + rvalid latency + 1 cycle.
//     Minimum 3 cycles per instruction with zero-wait memory.
//   PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
//   rvalid outside WAIT is ignored. gnt outside REQ is ignored.
//   enable_step_i low never aborts a granted access; the FSM parks in IDLE after
//   the current word is delivered or dropped.
// TESTING
//   1 Reset: rst_i=0 two cycles -> inst_valid_o=0, mem_req_o=0, busy_o=0,
//     mem_adres_o=RESET_PC.
//   2 Streaming, zero-wait memory (gnt same cycle, rvalid next), ready tied 1 ->
//     Decode sees PCs 0x0,0x4,0x8,0xC with matching rdata, one word every 3 cycles.
//   3 Back-pressure: inst_ready_i=0 for 5 cycles in HOLD -> instruction_o and
//     inst_pc_o stable, no mem_req_o; on ready=1 next req is to pc+4.
//   4 Redirect in WAIT: target=0x100, stale rvalid arrives 2 cycles later ->
//     the word is discarded (inst_valid_o stays 0); next req address=0x100.
//   5 Wrap: RESET_PC=0xFFFF_FFFC -> first word PC 0xFFFF_FFFC, next req addr 0x0.
//   6 Reset mid-WAIT, then rvalid after reset -> ignored; FSM in IDLE,
//     pc=RESET_PC, no inst_valid_o.

Source files
------------

// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
//
// Fetch-stage sequencer. Owns the program counter, issues at most one
// instruction-memory read at a time (req/gnt address phase, then rvalid data
// phase), parks the returned word in a one-entry buffer and presents it to
// Decode over a valid/ready handshake. A redirect from Execute replaces the PC
// and marks any response still in flight as stale so it is thrown away.
//
// Parameters
//   RESET_PC       PC loaded on reset
//   PC_STEP        byte increment of the PC per delivered instruction
//
// Ports
//   clk_i          clock, everything on the rising edge
//   rst_i          synchronous active-low reset
//   enable_step_i  fetch enable; low stops new requests (never aborts one)
//   redirect_i     one-cycle redirect strobe
//   redirect_pc_i  redirect target; bits [1:0] are forced to zero
//   mem_req_o      memory read request (held until granted)
//   mem_adres_o    request address, always the current PC
//   mem_gnt_i      request accepted this cycle (only looked at in REQ)
//   mem_rvalid_i   read data valid (only looked at in WAIT)
//   mem_rdata_i    read data
//   inst_valid_o   instruction buffer holds a word for Decode
//   instruction_o  buffered instruction
//   inst_pc_o      PC of the buffered instruction
//   inst_ready_i   Decode takes the buffered word this cycle
//   busy_o         controller is not idle
//
// All outputs come straight from flops; their next values are derived from
// the next-state values so they line up with the state register.
// -----------------------------------------------------------------------------
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_step_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_adres_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] instruction_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        HOLD = 2'b11
    } state_e;

    localparam logic [31:0] PC_INC = 32'(PC_STEP);

    // Instructions are word aligned: the low two target bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] target);
        return target & 32'hFFFF_FFFC;
    endfunction

    // Sequential PC; wraps modulo 2^32 by plain 32-bit addition.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + PC_INC;
    endfunction

    // Where to go once the current access has been delivered or dropped.
    function automatic state_e after_access(input logic enable);
        state_e nxt;
        if (enable) begin
            nxt = REQ;
        end else begin
            nxt = IDLE;
        end
        return nxt;
    endfunction

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_adres_q, mem_adres_d;
    logic        busy_q, busy_d;

    // Next-state, PC, stale-flag and instruction-buffer logic.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        inst_valid_d = inst_valid_q;
        instr_d      = instr_q;
        inst_pc_d    = inst_pc_q;

        case (state_q)
            IDLE: begin
                if (redirect_i) begin
                    pc_d = align_pc(redirect_pc_i);
                end else begin
                    pc_d = pc_q;
                end
                state_d = after_access(enable_step_i);
            end

            // The request stays up until granted, whatever enable does.
            REQ: begin
                if (mem_gnt_i) begin
                    state_d = WAIT;
                    // A redirect in the grant cycle makes the access stale.
                    drop_d  = redirect_i;
                    if (redirect_i) begin
                        pc_d = align_pc(redirect_pc_i);
                    end else begin
                        pc_d = pc_q;
                    end
                end else if (redirect_i) begin
                    // Not yet accepted: simply re-aim the pending request.
                    pc_d    = align_pc(redirect_pc_i);
                    state_d = REQ;
                end else begin
                    state_d = REQ;
                end
            end

            WAIT: begin
                if (mem_rvalid_i && redirect_i) begin
                    // Data arrives together with a redirect: it is already stale.
                    pc_d    = align_pc(redirect_pc_i);
                    drop_d  = 1'b0;
                    state_d = after_access(enable_step_i);
                end else if (mem_rvalid_i && drop_q) begin
                    drop_d  = 1'b0;
                    state_d = after_access(enable_step_i);
                end else if (mem_rvalid_i) begin
                    instr_d      = mem_rdata_i;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    pc_d         = next_pc(pc_q);
                    state_d      = HOLD;
                end else if (redirect_i) begin
                    // Keep waiting for the response, but remember to bin it.
                    pc_d    = align_pc(redirect_pc_i);
                    drop_d  = 1'b1;
                    state_d = WAIT;
                end else begin
                    state_d = WAIT;
                end
            end

            HOLD: begin
                if (redirect_i) begin
                    inst_valid_d = 1'b0;
                    pc_d         = align_pc(redirect_pc_i);
                    state_d      = after_access(enable_step_i);
                end else if (inst_ready_i) begin
                    inst_valid_d = 1'b0;
                    state_d      = after_access(enable_step_i);
                end else begin
                    state_d = HOLD;
                end
            end

            default: begin
                state_d      = IDLE;
                drop_d       = 1'b0;
                inst_valid_d = 1'b0;
            end
        endcase
    end

    // Output values for the next cycle, decoded from the next state.
    always_comb begin
        mem_req_d   = (state_d == REQ);
        mem_adres_d = pc_d;
        busy_d      = (state_d != IDLE);
    end

    // State, PC and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            instr_q      <= 32'h0000_0000;
            inst_pc_q    <= 32'h0000_0000;
            mem_req_q    <= 1'b0;
            mem_adres_q  <= RESET_PC;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            inst_valid_q <= inst_valid_d;
            instr_q      <= instr_d;
            inst_pc_q    <= inst_pc_d;
            mem_req_q    <= mem_req_d;
            mem_adres_q  <= mem_adres_d;
            busy_q       <= busy_d;
        end
    end

    assign mem_req_o     = mem_req_q;
    assign mem_adres_o   = mem_adres_q;
    assign inst_valid_o  = inst_valid_q;
    assign instruction_o = instr_q;
    assign inst_pc_o     = inst_pc_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_fetch_controller.sv
// -----------------------------------------------------------------------------
// tb_fetch_controller
//
// Directed bench for fetch_controller. A small memory model grants requests
// in the request cycle and answers after a programmable delay; every response
// that should reach Decode is pushed to a scoreboard when it is driven and
// popped when Decode accepts a word. A second instance with RESET_PC at the
// top of the address space shares all inputs and runs in lock-step, which
// exposes PC wrap-around.
// -----------------------------------------------------------------------------
module tb_fetch_controller;

    logic        clk_i;
    logic        rst_i;
    logic        enable_step_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        mem_req_o;
    logic [31:0] mem_adres_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] instruction_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;
    logic        busy_o;

    logic        w_mem_req_o;
    logic [31:0] w_mem_adres_o;
    logic        w_inst_valid_o;
    logic [31:0] w_instruction_o;
    logic [31:0] w_inst_pc_o;
    logic        w_busy_o;

    fetch_controller u_dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .enable_step_i (enable_step_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .mem_req_o     (mem_req_o),
        .mem_adres_o   (mem_adres_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .instruction_o (instruction_o),
        .inst_pc_o     (inst_pc_o),
        .inst_ready_i  (inst_ready_i),
        .busy_o        (busy_o)
    );

    fetch_controller #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .enable_step_i (enable_step_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .mem_req_o     (w_mem_req_o),
        .mem_adres_o   (w_mem_adres_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .inst_valid_o  (w_inst_valid_o),
        .instruction_o (w_instruction_o),
        .inst_pc_o     (w_inst_pc_o),
        .inst_ready_i  (inst_ready_i),
        .busy_o        (w_busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          pops = 0;
    int          last_pop_cyc = 0;
    bit          cad_en = 1'b0;

    logic [63:0] sb_q[$];
    bit          pend_active = 1'b0;
    bit          pend_stale = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_cnt = 0;
    int          rv_delay = 0;
    bit          resp_stale = 1'b0;
    logic [31:0] resp_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard/memory bookkeeping for the coming edge, the edge,
    // then new memory-side inputs driven at the falling edge.
    task automatic tick();
        logic [63:0] exp;
        if (rst_i && inst_valid_o && inst_ready_i && !redirect_i) begin
            check1("sb_nonempty", (sb_q.size() != 0), 1'b1);
            if (sb_q.size() != 0) begin
                exp = sb_q.pop_front();
                check32("pop_pc", inst_pc_o, exp[63:32]);
                check32("pop_data", instruction_o, exp[31:0]);
            end
            if (pops == 0) begin
                check32("wrap_first_pc", w_inst_pc_o, 32'hFFFF_FFFC);
            end
            if (cad_en && pops > 0) begin
                check32("cadence", 32'(cyc - last_pop_cyc), 32'd3);
            end
            pops++;
            last_pop_cyc = cyc;
        end
        if (!rst_i) begin
            pend_stale = 1'b1;
        end else begin
            if (mem_rvalid_i && !resp_stale && !redirect_i) begin
                sb_q.push_back({resp_addr, mem_word(resp_addr)});
            end
            if (redirect_i && pend_active) begin
                pend_stale = 1'b1;
            end
            if (mem_gnt_i) begin
                pend_active = 1'b1;
                pend_addr   = mem_adres_o;
                pend_stale  = redirect_i;
                pend_cnt    = rv_delay;
            end
        end
        @(posedge clk_i);
        cyc++;
        @(negedge clk_i);
        redirect_i   = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_gnt_i    = 1'b0;
        if (pend_active) begin
            if (pend_cnt == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = mem_word(pend_addr);
                resp_addr    = pend_addr;
                resp_stale   = pend_stale;
                pend_active  = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        if (mem_req_o && rst_i) begin
            mem_gnt_i = 1'b1;
        end
    endtask

    task automatic run_until_pops(input int target, input int budget);
        int n;
        n = 0;
        while (pops < target && n < budget) begin
            tick();
            n++;
        end
        check32("pops_reached", 32'(pops), 32'(target));
    endtask

    initial begin
        rst_i         = 1'b0;
        enable_step_i = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        mem_gnt_i     = 1'b0;
        mem_rvalid_i  = 1'b0;
        mem_rdata_i   = 32'h0;
        inst_ready_i  = 1'b0;

        // Reset held for two cycles
        tick();
        tick();
        check1("rst_valid", inst_valid_o, 1'b0);
        check1("rst_req", mem_req_o, 1'b0);
        check1("rst_busy", busy_o, 1'b0);
        check32("rst_adres", mem_adres_o, 32'h0000_0000);
        check32("rst_adres_wrap", w_mem_adres_o, 32'hFFFF_FFFC);

        // Streaming with zero-wait memory, ready tied high
        rst_i         = 1'b1;
        enable_step_i = 1'b1;
        inst_ready_i  = 1'b1;
        cad_en        = 1'b1;
        run_until_pops(1, 10);
        check1("wrap_req", w_mem_req_o, 1'b1);
        check32("wrap_next_adres", w_mem_adres_o, 32'h0000_0000);
        run_until_pops(4, 40);
        cad_en = 1'b0;
        check32("stream_next_adres", mem_adres_o, 32'h0000_0010);

        // Back-pressure in HOLD
        inst_ready_i = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check1("bp_valid", inst_valid_o, 1'b1);
            check32("bp_pc", inst_pc_o, 32'h0000_0010);
            check32("bp_data", instruction_o, mem_word(32'h0000_0010));
            check1("bp_noreq", mem_req_o, 1'b0);
            tick();
        end
        inst_ready_i = 1'b1;
        tick();
        check32("bp_pops", 32'(pops), 32'd5);
        check1("bp_req", mem_req_o, 1'b1);
        check32("bp_adres", mem_adres_o, 32'h0000_0014);

        // Redirect while waiting, stale response two cycles later
        rv_delay = 2;
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0100;
        tick();
        check1("rd_valid0", inst_valid_o, 1'b0);
        check1("rd_noreq", mem_req_o, 1'b0);
        tick();
        check1("rd_rvalid_driven", mem_rvalid_i, 1'b1);
        check1("rd_valid1", inst_valid_o, 1'b0);
        check1("rd_busy", busy_o, 1'b1);
        tick();
        check1("rd_valid2", inst_valid_o, 1'b0);
        check1("rd_req", mem_req_o, 1'b1);
        check32("rd_adres", mem_adres_o, 32'h0000_0100);
        rv_delay = 0;
        run_until_pops(6, 10);

        // Reset in WAIT, response arrives after reset
        rv_delay = 1;
        tick();
        check1("mw_busy", busy_o, 1'b1);
        rst_i = 1'b0;
        tick();
        rst_i         = 1'b1;
        enable_step_i = 1'b0;
        check1("mw_rvalid_driven", mem_rvalid_i, 1'b1);
        tick();
        check1("mw_busy_after", busy_o, 1'b0);
        check1("mw_req", mem_req_o, 1'b0);
        check1("mw_valid", inst_valid_o, 1'b0);
        check32("mw_adres", mem_adres_o, 32'h0000_0000);
        check32("mw_adres_wrap", w_mem_adres_o, 32'hFFFF_FFFC);
        tick();
        check1("mw_valid_late", inst_valid_o, 1'b0);
        rv_delay = 0;

        // Redirect in IDLE with misaligned target
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0203;
        tick();
        check32("idle_rd_adres", mem_adres_o, 32'h0000_0200);
        check1("idle_rd_busy", busy_o, 1'b0);
        enable_step_i = 1'b1;
        tick();
        check1("idle_rd_req", mem_req_o, 1'b1);
        check32("idle_rd_req_adres", mem_adres_o, 32'h0000_0200);
        run_until_pops(7, 10);
        check32("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
